enigma_rotor_stepper: RTL
=========================

// Module: enigma_rotor_stepper
// PURPOSE
//  Key-press sequencer and rotor-position controller for the enigma core. Detects each
//  new keystroke on the 5-bit keyboard bus (5'b11111 = no key) and steps the three
//  rotor positions once per keystroke using odometer carry with notch turnover.
//  Drives the latched key and positions into the combinational enigma core.
//  Latches the core's result as a lamp output that holds until the key is released.
// PARAMETERS
//  NOTCH_RIGHT  21  right-rotor position at which the next step carries into mid (rotor III 'V')
//  NOTCH_MID    4   mid-rotor position at which a carry also steps left (rotor II 'E')
// PORTS
//  clk        in   1  system clock; all state updates on posedge
//  restart    in   1  synchronous active-high reset
//  key_in     in   5  keyboard code: 0..25 = letter, 31 = no key, 26..30 = invalid
//  load       in   1  load start positions (honoured only in WAIT_REL/ARMED)
//  load_left  in   5  start position for left rotor (0..25)
//  load_mid   in   5  start position for mid rotor (0..25)
//  load_right in   5  start position for right rotor (0..25)
//  core_out   in   5  letter returned by the enigma core
//  key_core   out  5  latched key presented to the core
//  pos_left   out  5  left rotor position to the core
//  pos_mid    out  5  mid rotor position to the core
//  pos_right  out  5  right rotor position to the core
//  lamp_out   out  5  latched encrypted letter
//  lamp_valid out  1  lamp_out is valid for the current keystroke
//  busy       out  1  high in STEP and ENCODE
// BEHAVIOUR
//  Reset: state=WAIT_REL, pos_*=0, key_core=31, lamp_out=31, lamp_valid=0.
//  restart wins over every event, including mid-STEP/ENCODE; no partial step survives.
//  States:
//   WAIT_REL: key_in==31 -> ARMED. A key held through reset never counts as a press.
//   ARMED: key_in in 0..25 -> key_core<=key_in, STEP. key_in 26..30 is ignored; stay.
//   STEP: one cycle. Positions update per the stepping rule. -> ENCODE.
//   ENCODE: one cycle. The core sees the new positions and key_core.
//      lamp_out<=core_out, lamp_valid<=1. -> WAIT_REL.
//   WAIT_REL: lamp_valid stays 1 until key_in==31.
//      On leaving WAIT_REL, lamp_valid<=0; lamp_out holds its value.
//  Latency: key sampled in ARMED at edge N; positions step at N+1; lamp_valid=1 after N+2.
//  One keystroke gives exactly one step, however long the key is held.
//  A key change without an intervening 31 is not a new press.
//  load: in WAIT_REL/ARMED, pos_*<=load_* (each reduced: values >25 load as 0).
//    The state is unchanged. load takes priority over a same-cycle press in ARMED, and the
//    press is taken the next cycle if still held. Ignored in STEP/ENCODE.
//  Stepping rule (evaluated on pre-step values, all mod 26):
//   right<=right+1 (25 wraps to 0).
//   Mid steps if right==NOTCH_RIGHT. Left steps if mid steps and mid==NOTCH_MID.
// CONFIGURATION
//  ENIGMA_DOUBLE_STEP_EN defined: historical double-step.
//    If mid==NOTCH_MID at STEP, mid and left both step, independent of right.
//    A right-notch carry in the same STEP does not add a second mid step.
//  Undefined: pure odometer per the stepping rule above.
// TESTING
//  1 restart held 3 cycles, key_in=31 -> pos=0/0/0, lamp_out=31, lamp_valid=0, busy=0.
//  2 pos 0/0/0, key_in=8 held 10 cycles -> pos_right=1 only.
//    lamp_valid rises 3 edges after the press, lamp_out=core_out. Release -> lamp_valid=0.
//  3 load right=25, mid=0 -> press -> right=0, mid=0. Load right=21, mid=0 -> press -> 22/1.
//  4 load left=0, mid=4, right=10, press:
//    with ENIGMA_DOUBLE_STEP_EN -> 1/5/11; without -> 0/4/11.
//  5 key_in=28 in ARMED -> no step, busy=0. Key 8 then 23 with no 31 between -> one step.
//  6 restart asserted during ENCODE -> next cycle pos=0/0/0, lamp_valid=0, state WAIT_REL.

Source files
------------

// File: rtl/enigma_rotor_stepper_if.sv
// ---------------------------------------------------------------------------
// enigma_rotor_stepper_if
// Bundles the keyboard, load, core-return and core-drive signals of the rotor
// stepper so the stepper and its surroundings connect through one port.
//   key_in     keyboard code (0..25 letter, 31 no key, 26..30 invalid)
//   load       request to load start positions
//   load_left  start position for left rotor
//   load_mid   start position for mid rotor
//   load_right start position for right rotor
//   core_out   letter returned by the combinational enigma core
//   key_core   latched key presented to the core
//   pos_left   left rotor position to the core
//   pos_mid    mid rotor position to the core
//   pos_right  right rotor position to the core
//   lamp_out   latched encrypted letter
//   lamp_valid lamp_out belongs to the current keystroke
//   busy       stepper is in STEP or ENCODE
// The master modport is the keyboard/core side, the slave modport the stepper.
// ---------------------------------------------------------------------------
interface enigma_rotor_stepper_if;
   logic [4:0] key_in;
   logic       load;
   logic [4:0] load_left;
   logic [4:0] load_mid;
   logic [4:0] load_right;
   logic [4:0] core_out;
   logic [4:0] key_core;
   logic [4:0] pos_left;
   logic [4:0] pos_mid;
   logic [4:0] pos_right;
   logic [4:0] lamp_out;
   logic       lamp_valid;
   logic       busy;

   modport master (
      output key_in, load, load_left, load_mid, load_right, core_out,
      input  key_core, pos_left, pos_mid, pos_right, lamp_out, lamp_valid, busy
   );

   modport slave (
      input  key_in, load, load_left, load_mid, load_right, core_out,
      output key_core, pos_left, pos_mid, pos_right, lamp_out, lamp_valid, busy
   );
endinterface

// File: rtl/enigma_rotor_stepper.sv
// ---------------------------------------------------------------------------
// enigma_rotor_stepper
// Key-press sequencer and rotor-position controller for the enigma core.
// Each new keystroke (a letter code following a 31 "no key") steps the three
// rotors once with odometer carry and notch turnover, then latches the core
// result onto the lamp until the key is released.
// Ports:
//   clk      system clock, all state updates on posedge
//   restart  synchronous active-high reset
//   bus      enigma_rotor_stepper_if.slave (keyboard, load, core signals)
// Parameters:
//   NOTCH_RIGHT  right position whose step carries into the mid rotor
//   NOTCH_MID    mid position whose carry also steps the left rotor
// Configuration macro:
//   ENIGMA_DOUBLE_STEP_EN  when defined, the historical double-step anomaly
//                          is enabled (mid at its notch steps itself and left)
// ---------------------------------------------------------------------------
module enigma_rotor_stepper #(
   parameter int NOTCH_RIGHT = 21,
   parameter int NOTCH_MID   = 4
) (
   input logic                   clk,
   input logic                   restart,
   enigma_rotor_stepper_if.slave bus
);

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      ARMED    = 2'd1,
      STEP     = 2'd2,
      ENCODE   = 2'd3
   } state_t;

   localparam logic [4:0] NO_KEY = 5'd31;

   state_t     r_state;
   logic [4:0] r_posLeft;
   logic [4:0] r_posMid;
   logic [4:0] r_posRight;
   logic [4:0] r_keyCore;
   logic [4:0] r_lampOut;
   logic       r_lampValid;

   state_t     w_nextState;
   logic [4:0] w_nextLeft;
   logic [4:0] w_nextMid;
   logic [4:0] w_nextRight;
   logic [4:0] w_nextKeyCore;
   logic [4:0] w_nextLampOut;
   logic       w_nextLampValid;
   logic       w_rightAtNotch;
   logic       w_midAtNotch;
   logic       w_midStep;
   logic       w_leftStep;

   // Rotor positions live in 0..25; anything at or past 25 wraps to 0.
   function automatic logic [4:0] inc26(input logic [4:0] v);
      return (v >= 5'd25) ? 5'd0 : v + 5'd1;
   endfunction

   // Out-of-range load values are treated as position 0 rather than trusted.
   function automatic logic [4:0] reduce26(input logic [4:0] v);
      return (v > 5'd25) ? 5'd0 : v;
   endfunction

   assign w_rightAtNotch = (r_posRight == 5'(NOTCH_RIGHT));
   assign w_midAtNotch   = (r_posMid == 5'(NOTCH_MID));

   // Carry decisions are made on the pre-step positions. In double-step mode
   // a mid rotor sitting on its notch drags itself and the left rotor along
   // even without a right-rotor carry, and a simultaneous right carry still
   // produces only a single mid step.
`ifdef ENIGMA_DOUBLE_STEP_EN
   assign w_midStep  = w_rightAtNotch || w_midAtNotch;
   assign w_leftStep = w_midAtNotch;
`else
   assign w_midStep  = w_rightAtNotch;
   assign w_leftStep = w_rightAtNotch && w_midAtNotch;
`endif

   // State register and datapath registers. restart beats everything, so a
   // keystroke caught mid-STEP or mid-ENCODE leaves no trace afterwards.
   always_ff @(posedge clk) begin
      if (restart) begin
         r_state     <= WAIT_REL;
         r_posLeft   <= 5'd0;
         r_posMid    <= 5'd0;
         r_posRight  <= 5'd0;
         r_keyCore   <= NO_KEY;
         r_lampOut   <= NO_KEY;
         r_lampValid <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_posLeft   <= w_nextLeft;
         r_posMid    <= w_nextMid;
         r_posRight  <= w_nextRight;
         r_keyCore   <= w_nextKeyCore;
         r_lampOut   <= w_nextLampOut;
         r_lampValid <= w_nextLampValid;
      end
   end

   // Next-state and next-datapath logic. Everything holds by default.
   // Starting in WAIT_REL means a key held through reset has to be released
   // before it can count, and returning there after ENCODE is what limits a
   // held key to a single step. load wins over a same-cycle press in ARMED
   // and also keeps WAIT_REL from advancing that cycle; the press is simply
   // seen again next cycle if the key is still down.
   always_comb begin
      w_nextState     = r_state;
      w_nextLeft      = r_posLeft;
      w_nextMid       = r_posMid;
      w_nextRight     = r_posRight;
      w_nextKeyCore   = r_keyCore;
      w_nextLampOut   = r_lampOut;
      w_nextLampValid = r_lampValid;
      case (r_state)
         WAIT_REL: begin
            if (bus.load) begin
               w_nextLeft  = reduce26(bus.load_left);
               w_nextMid   = reduce26(bus.load_mid);
               w_nextRight = reduce26(bus.load_right);
            end else if (bus.key_in == NO_KEY) begin
               w_nextState     = ARMED;
               w_nextLampValid = 1'b0;
            end
         end
         ARMED: begin
            if (bus.load) begin
               w_nextLeft  = reduce26(bus.load_left);
               w_nextMid   = reduce26(bus.load_mid);
               w_nextRight = reduce26(bus.load_right);
            end else if (bus.key_in <= 5'd25) begin
               w_nextKeyCore = bus.key_in;
               w_nextState   = STEP;
            end
         end
         STEP: begin
            w_nextRight = inc26(r_posRight);
            if (w_midStep) begin
               w_nextMid = inc26(r_posMid);
            end
            if (w_leftStep) begin
               w_nextLeft = inc26(r_posLeft);
            end
            w_nextState = ENCODE;
         end
         ENCODE: begin
            w_nextLampOut   = bus.core_out;
            w_nextLampValid = 1'b1;
            w_nextState     = WAIT_REL;
         end
         default: begin
            w_nextState = WAIT_REL;
         end
      endcase
   end

   assign bus.key_core   = r_keyCore;
   assign bus.pos_left   = r_posLeft;
   assign bus.pos_mid    = r_posMid;
   assign bus.pos_right  = r_posRight;
   assign bus.lamp_out   = r_lampOut;
   assign bus.lamp_valid = r_lampValid;
   assign bus.busy       = (r_state == STEP) || (r_state == ENCODE);

endmodule
